// File: rtl/even_parity.sv
// Three-bit even-parity generator with a registered, handshaked side path
// that also verifies received parity and keeps saturating word statistics.
module even_parity #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    input  logic             in_valid,
    input  logic             chk_en,
    input  logic             chk_bit,
    output logic             result,
    output logic             result_q,
    output logic             out_valid,
    output logic             err_q,
    output logic             stream_par,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] odd_cnt
);

    logic             mismatch;
    logic             word_full;
    logic             odd_full;
    logic [CNT_W-1:0] word_nxt;
    logic [CNT_W-1:0] odd_nxt;

    assign result    = x ^ y ^ z;
    assign mismatch  = chk_en & (chk_bit ^ result);
    assign word_full = &word_cnt;
    assign odd_full  = &odd_cnt;

    // Counters stop at all-ones; each saturates independently.
    always_comb begin
        word_nxt = word_cnt;
        odd_nxt  = odd_cnt;
        if (in_valid && !word_full) begin
            word_nxt = word_cnt + CNT_W'(1);
        end
        if (in_valid && result && !odd_full) begin
            odd_nxt = odd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= 1'b0;
            out_valid  <= 1'b0;
            err_q      <= 1'b0;
            stream_par <= 1'b0;
            word_cnt   <= '0;
            odd_cnt    <= '0;
        end else begin
            out_valid <= in_valid;
            err_q     <= in_valid & mismatch;
            word_cnt  <= word_nxt;
            odd_cnt   <= odd_nxt;
            if (in_valid) begin
                result_q   <= result;
                stream_par <= stream_par ^ result;
            end
        end
    end

endmodule

// File: tb/tb_even_parity.sv
// Self-checking bench for even_parity: directed scenarios plus a randomized
// run scored against a behavioural model (default and 2-bit counter widths).
module tb_even_parity;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    logic x = 1'b0, y = 1'b0, z = 1'b0;
    logic in_valid = 1'b0, chk_en = 1'b0, chk_bit = 1'b0;

    logic       r8, rq8, ov8, err8, sp8;
    logic [7:0] wc8, oc8;
    logic       r2, rq2, ov2, err2, sp2;
    logic [1:0] wc2, oc2;

    int checks = 0;
    int errors = 0;

    int m_rq, m_ov, m_err, m_sp;
    int m_wc8, m_oc8, m_wc2, m_oc2;

    always #5 if (clk_en) clk = ~clk;

    even_parity #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .in_valid(in_valid), .chk_en(chk_en), .chk_bit(chk_bit),
        .result(r8), .result_q(rq8), .out_valid(ov8), .err_q(err8),
        .stream_par(sp8), .word_cnt(wc8), .odd_cnt(oc8)
    );

    even_parity #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
        .in_valid(in_valid), .chk_en(chk_en), .chk_bit(chk_bit),
        .result(r2), .result_q(rq2), .out_valid(ov2), .err_q(err2),
        .stream_par(sp2), .word_cnt(wc2), .odd_cnt(oc2)
    );

    // Reference: parity is the count of ones modulo two; counters clamp.
    task automatic tick();
        int p;
        @(posedge clk);
        p = (int'(x) + int'(y) + int'(z)) % 2;
        if (rst) begin
            m_rq = 0; m_ov = 0; m_err = 0; m_sp = 0;
            m_wc8 = 0; m_oc8 = 0; m_wc2 = 0; m_oc2 = 0;
        end else if (in_valid) begin
            m_rq  = p;
            m_ov  = 1;
            m_err = (chk_en && (int'(chk_bit) != p)) ? 1 : 0;
            m_sp  = (m_sp + p) % 2;
            m_wc8 = (m_wc8 < 255) ? m_wc8 + 1 : 255;
            m_wc2 = (m_wc2 < 3) ? m_wc2 + 1 : 3;
            m_oc8 = (p == 1 && m_oc8 < 255) ? m_oc8 + 1 : m_oc8;
            m_oc2 = (p == 1 && m_oc2 < 3) ? m_oc2 + 1 : m_oc2;
        end else begin
            m_ov = 0; m_err = 0;
        end
        #1;
    endtask

    task automatic drive(input logic [2:0] w, input logic v,
                         input logic ce, input logic cb);
        {x, y, z} = w;
        in_valid = v;
        chk_en = ce;
        chk_bit = cb;
    endtask

    task automatic do_reset();
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_comb();
        logic [7:0] tbl;
        tbl = 8'b1001_0110;
        for (int v = 0; v < 8; v++) begin
            {x, y, z} = 3'(v);
            #100;
            checks++;
            if (r8 !== tbl[v]) begin
                errors++;
                $display("FAIL comb_%0d got %b exp %b", v, r8, tbl[v]);
            end
            checks++;
            if (r2 !== tbl[v]) begin
                errors++;
                $display("FAIL comb2_%0d got %b exp %b", v, r2, tbl[v]);
            end
        end
    endtask

    task automatic test_reset();
        clk_en = 1'b1;
        #2;
        do_reset();
        checks++;
        if ({rq8, ov8, err8, sp8} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {rq8, ov8, err8, sp8});
        end
        checks++;
        if (wc8 !== 8'd0 || oc8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", wc8, oc8);
        end
    endtask

    task automatic test_stream();
        logic [2:0] words [3];
        logic [2:0] expq;
        words = '{3'b011, 3'b101, 3'b111};
        expq = 3'b100;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(words[i], 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (ov8 !== 1'b1 || rq8 !== expq[i]) begin
                errors++;
                $display("FAIL stream_%0d got ov=%b rq=%b exp ov=1 rq=%b",
                         i, ov8, rq8, expq[i]);
            end
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (ov8 !== 1'b0 || sp8 !== 1'b1 || wc8 !== 8'd3 || oc8 !== 8'd1) begin
            errors++;
            $display("FAIL stream_final got ov=%b sp=%b wc=%0d oc=%0d exp 0 1 3 1",
                     ov8, sp8, wc8, oc8);
        end
    endtask

    task automatic test_check();
        drive(3'b001, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (err8 !== 1'b0) begin
            errors++;
            $display("FAIL chk_match got %b exp 0", err8);
        end
        drive(3'b001, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (err8 !== 1'b1) begin
            errors++;
            $display("FAIL chk_mismatch got %b exp 1", err8);
        end
        drive(3'b001, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (err8 !== 1'b0) begin
            errors++;
            $display("FAIL chk_one_cycle got %b exp 0", err8);
        end
        drive(3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (err8 !== 1'b0 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL chk_disabled got err=%b ov=%b exp 0 1", err8, ov8);
        end
    endtask

    task automatic test_idle();
        int s_rq, s_sp, s_wc, s_oc;
        drive(3'b110, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (err8 !== 1'b1 || rq8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_pre got err=%b rq=%b exp 1 0", err8, rq8);
        end
        s_rq = m_rq; s_sp = m_sp; s_wc = m_wc8; s_oc = m_oc8;
        for (int i = 0; i < 3; i++) begin
            drive(3'($urandom_range(7)), 1'b0, 1'b1, 1'($urandom_range(1)));
            tick();
            checks++;
            if (ov8 !== 1'b0 || err8 !== 1'b0) begin
                errors++;
                $display("FAIL idle_flags_%0d got ov=%b err=%b exp 0 0",
                         i, ov8, err8);
            end
            checks++;
            if (int'(rq8) != s_rq || int'(sp8) != s_sp ||
                int'(wc8) != s_wc || int'(oc8) != s_oc) begin
                errors++;
                $display("FAIL idle_hold_%0d got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                         i, rq8, sp8, wc8, oc8, s_rq, s_sp, s_wc, s_oc);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'(i + 1), 1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(3'b111, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rq8, ov8, err8, sp8} !== 4'b0000 || wc8 !== 8'd0 || oc8 !== 8'd0) begin
            errors++;
            $display("FAIL midrst got %b wc=%0d oc=%0d exp 0000 0 0",
                     {rq8, ov8, err8, sp8}, wc8, oc8);
        end
        drive(3'b100, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (wc8 !== 8'd1 || oc8 !== 8'd1 || sp8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart got wc=%0d oc=%0d sp=%b exp 1 1 1",
                     wc8, oc8, sp8);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 1'b1, 1'b0, 1'b0);
            tick();
            checks++;
            if (int'(sp2) != (i + 1) % 2) begin
                errors++;
                $display("FAIL sat_sp_%0d got %b exp %0d", i, sp2, (i + 1) % 2);
            end
        end
        drive(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (wc2 !== 2'd3 || oc2 !== 2'd3 || sp2 !== 1'b0) begin
            errors++;
            $display("FAIL sat2 got wc=%0d oc=%0d sp=%b exp 3 3 0", wc2, oc2, sp2);
        end
        checks++;
        if (wc8 !== 8'd6 || oc8 !== 8'd6) begin
            errors++;
            $display("FAIL sat8 got wc=%0d oc=%0d exp 6 6", wc8, oc8);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(3'($urandom_range(7)), 1'($urandom_range(3) != 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            rst = ($urandom_range(24) == 0);
            #1;
            checks++;
            if (int'(r8) != (int'(x) + int'(y) + int'(z)) % 2) begin
                errors++;
                $display("FAIL rand_result_%0d got %b", i, r8);
            end
            tick();
            rst = 1'b0;
            checks++;
            if (int'(rq8) != m_rq || int'(ov8) != m_ov ||
                int'(err8) != m_err || int'(sp8) != m_sp) begin
                errors++;
                $display("FAIL rand_flags_%0d got %b%b%b%b exp %0d%0d%0d%0d",
                         i, rq8, ov8, err8, sp8, m_rq, m_ov, m_err, m_sp);
            end
            checks++;
            if (int'(wc8) != m_wc8 || int'(oc8) != m_oc8) begin
                errors++;
                $display("FAIL rand_cnt8_%0d got %0d/%0d exp %0d/%0d",
                         i, wc8, oc8, m_wc8, m_oc8);
            end
            checks++;
            if (int'(wc2) != m_wc2 || int'(oc2) != m_oc2 ||
                int'(rq2) != m_rq || int'(ov2) != m_ov ||
                int'(err2) != m_err || int'(sp2) != m_sp) begin
                errors++;
                $display("FAIL rand_w2_%0d got %0d/%0d exp %0d/%0d",
                         i, wc2, oc2, m_wc2, m_oc2);
            end
        end
    endtask

    initial begin
        test_comb();
        test_reset();
        test_stream();
        test_check();
        test_idle();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
